// File: rtl/led_frame_loader.sv
// Framed byte-stream parser feeding a WS2812 driver write port.
// Define LED_FRAME_CHECKSUM_EN to require a trailing XOR checksum byte.
module led_frame_loader #(
  parameter int NUM_LEDS = 8,
  parameter int TIMEOUT  = 12000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] rgb_data,
  output logic [7:0]  led_num,
  output logic        write,
  output logic        busy,
  output logic        frame_done,
  output logic        error
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [8:0] NLED = 9'(NUM_LEDS);

`ifdef LED_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_INDEX, S_COUNT, S_COLOR, S_CHECK
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_INDEX, S_COUNT, S_COLOR
  } state_e;
`endif

  state_e        state_q, state_d;
  // bit 8 latches once the index walks past 255
  logic [8:0]    idx_q, idx_d;
  logic [7:0]    rem_q, rem_d;
  logic [1:0]    phase_q, phase_d;
  logic [15:0]   asm_q, asm_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [7:0]    led_q, led_d;
  logic          write_q, write_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef LED_FRAME_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic acc;
  logic tmo_fire;

  assign in_ready   = ~reset;
  assign rgb_data   = rgb_q;
  assign led_num    = led_q;
  assign write      = write_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign error      = err_q;

  assign acc      = in_valid & ~reset;
  assign tmo_fire = (state_q != S_IDLE) && (tmo_q == TLAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    asm_d   = asm_q;
    tmo_d   = tmo_q + 1'b1;
    rgb_d   = rgb_q;
    led_d   = led_q;
    write_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef LED_FRAME_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (tmo_fire) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else if (acc) begin
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (in_data == 8'hA5) state_d = S_INDEX;
        end
        S_INDEX: begin
          idx_d   = {1'b0, in_data};
          state_d = S_COUNT;
`ifdef LED_FRAME_CHECKSUM_EN
          csum_d  = in_data;
`endif
        end
        S_COUNT: begin
          rem_d   = in_data;
          phase_d = 2'd0;
`ifdef LED_FRAME_CHECKSUM_EN
          csum_d  = csum_q ^ in_data;
`endif
          if (in_data == 8'd0) begin
`ifdef LED_FRAME_CHECKSUM_EN
            state_d = S_CHECK;
`else
            done_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            state_d = S_COLOR;
          end
        end
        S_COLOR: begin
`ifdef LED_FRAME_CHECKSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (phase_q == 2'd2) begin
            phase_d = 2'd0;
            rem_d   = rem_q - 8'd1;
            if (idx_q < NLED) begin
              write_d = 1'b1;
              rgb_d   = {asm_q, in_data};
              led_d   = idx_q[7:0];
            end
            if (!idx_q[8]) idx_d = idx_q + 9'd1;
            if (rem_q == 8'd1) begin
`ifdef LED_FRAME_CHECKSUM_EN
              state_d = S_CHECK;
`else
              done_d  = 1'b1;
              state_d = S_IDLE;
`endif
            end
          end else begin
            phase_d = phase_q + 2'd1;
            asm_d   = {asm_q[7:0], in_data};
          end
        end
`ifdef LED_FRAME_CHECKSUM_EN
        S_CHECK: begin
          if (in_data == csum_q) done_d = 1'b1;
          else                   err_d  = 1'b1;
          state_d = S_IDLE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d == S_IDLE) tmo_d = '0;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      phase_q <= '0;
      asm_q   <= '0;
      tmo_q   <= '0;
      rgb_q   <= '0;
      led_q   <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LED_FRAME_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
      asm_q   <= asm_d;
      tmo_q   <= tmo_d;
      rgb_q   <= rgb_d;
      led_q   <= led_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LED_FRAME_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
